// File: rtl/ham_deco_pipe.sv
// Two-stage pipelined Hamming(12,8) SEC decoder with valid/ready handshake on both sides.
// Define HAM_DECO_CNT_EN to build the saturating corrected/uncorrectable word counters.
module ham_deco_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [11:0]      i_code_in,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [7:0]       o_data_out,
  output logic [3:0]       o_syndrome,
  output logic             o_err_corr,
  output logic             o_err_uncorr,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_corr_cnt,
  output logic [CNT_W-1:0] o_uncorr_cnt
);

  // Syndrome of a codeword; the value is the 1-based position of a single flipped bit.
  function automatic logic [3:0] calc_syndrome(input logic [11:0] c);
    logic [3:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11];
    s[3] = c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
    return s;
  endfunction

  function automatic logic [7:0] extract_data(input logic [11:0] c);
    return {c[11:8], c[6:4], c[2]};
  endfunction

  // Stage 1: registered codeword and its syndrome
  logic        s1_v_q, s1_v_d;
  logic [11:0] s1_code_q, s1_code_d;
  logic [3:0]  s1_syn_q, s1_syn_d;

  // Stage 2: corrected output word
  logic        s2_v_q, s2_v_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  syn_q, syn_d;
  logic        corr_q, corr_d;
  logic        uncorr_q, uncorr_d;

  logic        s1_load;
  logic        s2_load;
  logic        in_hs;
  logic        out_hs;

  logic [11:0] fixed_code;
  logic        syn_is_corr;
  logic        syn_is_uncorr;

  // Handshake and load conditions
  always_comb begin
    s2_load = !s2_v_q || i_ready;
    s1_load = !s1_v_q || s2_load;
    o_ready = s1_load && !i_rst;
    in_hs   = i_valid && o_ready;
    out_hs  = s2_v_q && i_ready;
  end

  // Correction of the stage-1 word
  always_comb begin
    syn_is_corr   = (s1_syn_q != 4'd0) && (s1_syn_q <= 4'd12);
    syn_is_uncorr = (s1_syn_q >= 4'd13);
    fixed_code    = s1_code_q;
    for (int k = 0; k < 12; k++) begin
      if (s1_syn_q == 4'(k + 1)) begin
        fixed_code[k] = ~s1_code_q[k];
      end
    end
  end

  // Next-state for both stages
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_code_d = s1_code_q;
    s1_syn_d  = s1_syn_q;
    s2_v_d    = s2_v_q;
    data_d    = data_q;
    syn_d     = syn_q;
    corr_d    = corr_q;
    uncorr_d  = uncorr_q;

    if (s1_load) begin
      s1_v_d = i_valid;
      if (in_hs) begin
        s1_code_d = i_code_in;
        s1_syn_d  = calc_syndrome(i_code_in);
      end
    end

    // Output registers only change when a real word moves in; bubbles leave them untouched.
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        data_d   = extract_data(syn_is_corr ? fixed_code : s1_code_q);
        syn_d    = s1_syn_q;
        corr_d   = syn_is_corr;
        uncorr_d = syn_is_uncorr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v_q    <= 1'b0;
      s1_code_q <= 12'd0;
      s1_syn_q  <= 4'd0;
      s2_v_q    <= 1'b0;
      data_q    <= 8'd0;
      syn_q     <= 4'd0;
      corr_q    <= 1'b0;
      uncorr_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_code_q <= s1_code_d;
      s1_syn_q  <= s1_syn_d;
      s2_v_q    <= s2_v_d;
      data_q    <= data_d;
      syn_q     <= syn_d;
      corr_q    <= corr_d;
      uncorr_q  <= uncorr_d;
    end
  end

  assign o_valid      = s2_v_q;
  assign o_data_out   = data_q;
  assign o_syndrome   = syn_q;
  assign o_err_corr   = corr_q;
  assign o_err_uncorr = uncorr_q;

`ifdef HAM_DECO_CNT_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (i_cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_hs) begin
      if (corr_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end
      if (uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign o_corr_cnt   = corr_cnt_q;
  assign o_uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  logic unused_out_hs;

  assign unused_cnt_clr = i_cnt_clr;
  assign unused_out_hs  = out_hs;
  assign o_corr_cnt     = '0;
  assign o_uncorr_cnt   = '0;
`endif

endmodule

// File: tb/tb_ham_deco_pipe.sv
// Directed bench for ham_deco_pipe: decode classes, latency, streaming, backpressure,
// counter clear/saturation (counters run at CNT_W=2) and mid-stream reset.
module tb_ham_deco_pipe;

  localparam int unsigned CntW = 2;
`ifdef HAM_DECO_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_rdy;
  logic [11:0]     code;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      data;
  logic [3:0]      syn;
  logic            err_corr;
  logic            err_uncorr;
  logic            cnt_clr;
  logic [CntW-1:0] corr_cnt;
  logic [CntW-1:0] uncorr_cnt;

  int total  = 0;
  int passed = 0;

  ham_deco_pipe #(
    .CNT_W(CntW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .o_ready     (in_rdy),
    .i_code_in   (code),
    .o_valid     (out_valid),
    .i_ready     (out_ready),
    .o_data_out  (data),
    .o_syndrome  (syn),
    .o_err_corr  (err_corr),
    .o_err_uncorr(err_uncorr),
    .i_cnt_clr   (cnt_clr),
    .o_corr_cnt  (corr_cnt),
    .o_uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; code = 12'd0; out_ready = 1'b1; cnt_clr = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else passed++;
    total++; if (data !== 8'h00) $display("FAIL rst_data got %h want 00", data); else passed++;
    total++; if (syn !== 4'h0) $display("FAIL rst_syn got %h want 0", syn); else passed++;
    total++; if ({err_corr, err_uncorr} !== 2'b00)
      $display("FAIL rst_flags got %b want 00", {err_corr, err_uncorr}); else passed++;
    total++; if ({corr_cnt, uncorr_cnt} !== 4'd0)
      $display("FAIL rst_cnt got %h/%h want 0/0", corr_cnt, uncorr_cnt); else passed++;
    total++; if (in_rdy !== 1'b0) $display("FAIL rst_ready got %b want 0", in_rdy); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_rdy !== 1'b1) $display("FAIL post_rst_ready got %b want 1", in_rdy); else passed++;
    tick();
  endtask

  task automatic test_clean();
    in_valid = 1'b1; code = 12'hA27;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL clean_early got %b want 0", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL clean_valid got %b want 1", out_valid); else passed++;
    total++; if (data !== 8'hA5) $display("FAIL clean_data got %h want a5", data); else passed++;
    total++; if (syn !== 4'd0) $display("FAIL clean_syn got %0d want 0", syn); else passed++;
    total++; if ({err_corr, err_uncorr} !== 2'b00)
      $display("FAIL clean_flags got %b want 00", {err_corr, err_uncorr}); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL clean_drain got %b want 0", out_valid); else passed++;
    total++; if (corr_cnt !== 2'd0) $display("FAIL clean_cnt got %0d want 0", corr_cnt); else passed++;
  endtask

  task automatic test_data_err();
    in_valid = 1'b1; code = 12'hA67;
    tick(); in_valid = 1'b0; tick();
    total++; if (data !== 8'hA5) $display("FAIL derr_data got %h want a5", data); else passed++;
    total++; if (syn !== 4'd7) $display("FAIL derr_syn got %0d want 7", syn); else passed++;
    total++; if ({err_corr, err_uncorr} !== 2'b10)
      $display("FAIL derr_flags got %b want 10", {err_corr, err_uncorr}); else passed++;
    tick();
    total++; if (corr_cnt !== (CntEn ? 2'd1 : 2'd0))
      $display("FAIL derr_cnt got %0d want %0d", corr_cnt, CntEn ? 1 : 0); else passed++;
  endtask

  task automatic test_parity_err();
    in_valid = 1'b1; code = 12'hA26;
    tick(); in_valid = 1'b0; tick();
    total++; if (data !== 8'hA5) $display("FAIL perr_data got %h want a5", data); else passed++;
    total++; if (syn !== 4'd1) $display("FAIL perr_syn got %0d want 1", syn); else passed++;
    total++; if (err_corr !== 1'b1) $display("FAIL perr_corr got %b want 1", err_corr); else passed++;
    tick();
    total++; if (corr_cnt !== (CntEn ? 2'd2 : 2'd0))
      $display("FAIL perr_cnt got %0d want %0d", corr_cnt, CntEn ? 2 : 0); else passed++;
  endtask

  task automatic test_uncorr();
    // Bits 5 and 8 flipped: raw data {1011,000,1}
    in_valid = 1'b1; code = 12'hB07;
    tick(); in_valid = 1'b0; tick();
    total++; if (data !== 8'hB1) $display("FAIL unc_data got %h want b1", data); else passed++;
    total++; if (syn !== 4'd15) $display("FAIL unc_syn got %0d want 15", syn); else passed++;
    total++; if ({err_corr, err_uncorr} !== 2'b01)
      $display("FAIL unc_flags got %b want 01", {err_corr, err_uncorr}); else passed++;
    tick();
    total++; if (uncorr_cnt !== (CntEn ? 2'd1 : 2'd0))
      $display("FAIL unc_cnt got %0d want %0d", uncorr_cnt, CntEn ? 1 : 0); else passed++;
  endtask

  task automatic test_cnt_clr();
    in_valid = 1'b1; code = 12'hA26;
    tick(); in_valid = 1'b0; tick();
    total++; if ({out_valid, err_corr} !== 2'b11)
      $display("FAIL clr_pre got %b want 11", {out_valid, err_corr}); else passed++;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++; if ({corr_cnt, uncorr_cnt} !== 4'd0)
      $display("FAIL clr_cnt got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); else passed++;
  endtask

  task automatic test_boundaries();
    logic [11:0] cw [3] = '{12'hE27, 12'h227, 12'h226};
    logic [7:0]  dx [3] = '{8'hA5, 8'hA5, 8'h25};
    logic [3:0]  sx [3] = '{4'd11, 4'd12, 4'd13};
    logic [1:0]  fx [3] = '{2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; code = cw[i];
      tick(); in_valid = 1'b0; tick();
      total++; if ({data, syn, err_corr, err_uncorr} !== {dx[i], sx[i], fx[i]})
        $display("FAIL bound_%0d got d=%h s=%0d f=%b want d=%h s=%0d f=%b", i, data, syn,
                 {err_corr, err_uncorr}, dx[i], sx[i], fx[i]);
      else passed++;
      tick();
    end
    total++; if ({corr_cnt, uncorr_cnt} !== (CntEn ? {2'd2, 2'd1} : 4'd0))
      $display("FAIL bound_cnt got %0d/%0d", corr_cnt, uncorr_cnt); else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; code = 12'hA67;
      tick(); in_valid = 1'b0; tick(); tick();
      total++; if (corr_cnt !== (CntEn ? 2'd3 : 2'd0))
        $display("FAIL sat_%0d got %0d want %0d", i, corr_cnt, CntEn ? 3 : 0); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] cw [4] = '{12'h000, 12'hF77, 12'h362, 12'hA67};
    logic [7:0]  dx [4] = '{8'h00, 8'hFF, 8'h3C, 8'hA5};
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      code     = (i < 4) ? cw[i] : 12'd0;
      #1;
      total++; if (in_rdy !== 1'b1) $display("FAIL b2b_ready_%0d got %b want 1", i, in_rdy);
      else passed++;
      tick();
      if (i >= 1) begin
        total++; if ({out_valid, data} !== {1'b1, dx[i-1]})
          $display("FAIL b2b_word_%0d got v=%b d=%h want v=1 d=%h", i - 1, out_valid, data,
                   dx[i-1]);
        else passed++;
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_tail got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    logic [11:0] cw [4] = '{12'hF77, 12'h362, 12'hA67, 12'h000};
    logic [7:0]  dx [4] = '{8'hFF, 8'h3C, 8'hA5, 8'h00};
    logic [7:0]  got [4];
    int idx = 0;
    int got_n = 0;
    int acc_at5 = -1;
    bit acc;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      code      = (idx < 4) ? cw[idx] : 12'd0;
      #1;
      if (cyc == 5) begin
        acc_at5 = idx;
        total++; if (in_rdy !== 1'b1) $display("FAIL bp_release got %b want 1", in_rdy);
        else passed++;
      end
      if (cyc >= 2 && cyc < 5) begin
        total++; if ({in_rdy, out_valid, data} !== {1'b0, 1'b1, 8'hFF})
          $display("FAIL bp_hold_%0d got r=%b v=%b d=%h want r=0 v=1 d=ff", cyc, in_rdy,
                   out_valid, data);
        else passed++;
      end
      acc = in_valid && in_rdy;
      if (out_valid && out_ready) begin
        if (got_n < 4) got[got_n] = data;
        got_n++;
      end
      tick();
      if (acc) idx++;
      if (idx == 4 && got_n >= 4) break;
    end
    in_valid = 1'b0;
    total++; if (acc_at5 !== 2) $display("FAIL bp_accepted got %0d want 2", acc_at5); else passed++;
    total++; if (got_n !== 4) $display("FAIL bp_count got %0d want 4", got_n); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== dx[i]) $display("FAIL bp_word_%0d got %h want %h", i, got[i], dx[i]);
      else passed++;
    end
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_dup got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; code = 12'hA27;
    tick();
    code = 12'h362;
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, in_rdy} !== 2'b10)
      $display("FAIL rf_full got v=%b r=%b want v=1 r=0", out_valid, in_rdy); else passed++;
    rst = 1'b1;
    tick();
    total++; if ({out_valid, data, syn, err_corr, err_uncorr} !== 15'd0)
      $display("FAIL rf_clear got v=%b d=%h s=%0d", out_valid, data, syn); else passed++;
    total++; if ({corr_cnt, uncorr_cnt, in_rdy} !== 5'd0)
      $display("FAIL rf_cnt_ready got %0d/%0d r=%b want 0/0 r=0", corr_cnt, uncorr_cnt, in_rdy);
    else passed++;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (in_rdy !== 1'b1) $display("FAIL rf_ready got %b want 1", in_rdy); else passed++;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rf_discard got %b want 0", out_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_data_err();
    test_parity_err();
    test_uncorr();
    test_cnt_clr();
    test_boundaries();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_full();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
